// File: rtl/crc_rx_sched.sv
// RX FCS check sequencer: serialises 32-bit beats into a byte-wide CRC-32
// engine and reports per-frame FCS, length, runt and abort status.

module crc_rx #(
  parameter int          DATA_W = 8,
  parameter int          SUM_W  = 32,
  parameter logic [SUM_W-1:0] POLY = 32'hEDB88320
) (
  input  logic              clk,
  input  logic              start_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [SUM_W-1:0]  crc_o
);

  logic [SUM_W-1:0] crc_q;
  logic [SUM_W-1:0] crc_n;

  // LSB-first reflected update; start_i seeds from zero
  always_comb begin
    crc_n = start_i ? '0 : crc_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (crc_n[0] ^ data_i[i])
        crc_n = (crc_n >> 1) ^ POLY;
      else
        crc_n = crc_n >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (valid_i) crc_q <= crc_n;
  end

  assign crc_o = crc_q;

endmodule

module crc_rx_sched #(
  parameter logic [15:0] MIN_LEN = 16'd64,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_start_i,
  input  logic        in_last_i,
  input  logic [3:0]  in_keep_i,
  input  logic [31:0] in_data_i,
  output logic        done_o,
  output logic        ok_o,
  output logic        runt_o,
  output logic        abort_o,
  output logic [15:0] len_o
);

  typedef enum logic [1:0] {IDLE, BYTE, CHECK} st_t;

  st_t         st;
  logic        live;
  logic        have;
  logic        blast;
  logic [31:0] bdat;
  logic [1:0]  lane;
  logic [1:0]  lmax;
  logic [15:0] len;

  logic [2:0]  kn;
  logic        fin;
  logic        busy;
  logic        acc;
  logic        load;
  logic [15:0] len_inc;
  logic [15:0] len_nx;
  logic [31:0] sh;
  logic [7:0]  eng_data;
  logic        eng_start;
  logic [31:0] crc;

  always_comb begin
    kn = 3'd0;
    if (in_keep_i[0]) begin
      kn = 3'd1;
      if (in_keep_i[1]) begin
        kn = 3'd2;
        if (in_keep_i[2]) begin
          kn = 3'd3;
          if (in_keep_i[3]) kn = 3'd4;
        end
      end
    end
  end

  assign fin  = have && (lane == lmax);
  assign busy = (st == BYTE) && have;

  assign in_ready_o = live &&
    ((st == IDLE) ||
     ((st == BYTE) && (!have || (fin && !blast))));

  assign acc  = in_valid_i && in_ready_o;
  assign load = acc && ((st == BYTE) || in_start_i);

  assign len_inc = (len == 16'hFFFF) ? len : len + 16'd1;
  assign len_nx  = busy ? len_inc : len;

  // Zero seed plus inverted first four bytes equals the all-ones preset
  assign sh        = bdat >> {lane, 3'b000};
  assign eng_data  = sh[7:0] ^ {8{len < 16'd4}};
  assign eng_start = (len == 16'd0);

  crc_rx #(
    .DATA_W (8),
    .SUM_W  (32)
  ) u_crc (
    .clk     (clk),
    .start_i (eng_start),
    .valid_i (busy),
    .data_i  (eng_data),
    .crc_o   (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      live    <= 1'b0;
      have    <= 1'b0;
      blast   <= 1'b0;
      bdat    <= '0;
      lane    <= '0;
      lmax    <= '0;
      len     <= '0;
      done_o  <= 1'b0;
      ok_o    <= 1'b0;
      runt_o  <= 1'b0;
      abort_o <= 1'b0;
      len_o   <= '0;
    end else begin
      live   <= 1'b1;
      done_o <= 1'b0;
      unique case (st)
        IDLE: begin
          if (load) len <= '0;
        end
        BYTE: begin
          if (busy) len <= len_inc;
          if (acc) begin
            if (in_start_i) begin
              done_o  <= 1'b1;
              abort_o <= 1'b1;
              ok_o    <= 1'b0;
              runt_o  <= (len_nx < MIN_LEN);
              len_o   <= len_nx;
              len     <= '0;
            end
          end else if (fin) begin
            if (blast) st <= CHECK;
            else have <= 1'b0;
          end else if (have) begin
            lane <= lane + 2'd1;
          end
        end
        CHECK: begin
          done_o  <= 1'b1;
          ok_o    <= (crc == RESIDUE) && (len >= MIN_LEN);
          runt_o  <= (len < MIN_LEN);
          abort_o <= 1'b0;
          len_o   <= len;
          have    <= 1'b0;
          st      <= IDLE;
        end
        default: st <= IDLE;
      endcase
      if (load) begin
        bdat  <= in_data_i;
        blast <= in_last_i;
        lane  <= '0;
        lmax  <= 2'(kn - 3'd1);
        have  <= (kn != 3'd0);
        st    <= ((kn == 3'd0) && in_last_i) ? CHECK : BYTE;
      end
    end
  end

endmodule
